// File: rtl/tp_debug_sel.sv
// Debug group selector and pulse stretcher for the test-point driver.
// Define TP_STRETCH_EN to build the per-bit pulse-stretch counters.
module tp_debug_sel #(
    parameter int unsigned STRETCH = 8,
    parameter int unsigned BLANK   = 4
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic [13:0] GRP0,
    input  logic [13:0] GRP1,
    input  logic [13:0] GRP2,
    input  logic [13:0] GRP3,
    input  logic        SEL_WR,
    input  logic [1:0]  SEL_DATA,
    input  logic        EVT_CLR,
    output logic [13:0] TP_OUT,
    output logic [1:0]  TP_GRP,
    output logic        TP_BUSY,
    output logic [15:0] EVT_CNT
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t      state_q;
    logic [1:0]  grp_q;
    logic [3:0]  blk_q;
    logic [13:0] s_q, s_d;
    logic [13:0] sp_q, sp_d;
    logic [13:0] out_q, out_d;
    logic [15:0] evt_q;
    logic        run;
    logic        rise0;

    // Select the active debug group
    always_comb begin
        s_d = GRP0;
        case (grp_q)
            2'd0: s_d = GRP0;
            2'd1: s_d = GRP1;
            2'd2: s_d = GRP2;
            2'd3: s_d = GRP3;
            default: s_d = GRP0;
        endcase
    end

    // Outputs are live only in RUN with no switch request this cycle
    assign run = (state_q == ST_RUN) && !SEL_WR;

    // While blanking, s_prev follows the incoming level so exit sees no edge
    assign sp_d = (state_q == ST_BLANK) ? s_d : s_q;

`ifdef TP_STRETCH_EN
    logic [7:0]  cnt_q [14];
    logic [13:0] rise;
    logic [13:0] hold;

    // Rising edges and stretch-active flags
    always_comb begin
        rise = run ? (s_q & ~sp_q) : '0;
        hold = '0;
        for (int i = 0; i < 14; i++) begin
            hold[i] = (cnt_q[i] != 8'd0);
        end
        out_d = run ? (s_q | hold | rise) : '0;
    end

    assign rise0 = rise[0];

    // Per-bit stretch counters: load on edge, count down, clear when blanked
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < 14; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (!run) begin
                    cnt_q[i] <= 8'd0;
                end else if (rise[i]) begin
                    cnt_q[i] <= 8'(STRETCH - 1);
                end else if (cnt_q[i] != 8'd0) begin
                    cnt_q[i] <= cnt_q[i] - 8'd1;
                end
            end
        end
    end
`else
    // Plain pass-through of the registered group, gated by blanking
    always_comb begin
        out_d = run ? s_q : '0;
    end

    assign rise0 = run & s_q[0] & ~sp_q[0];
`endif

    // Input pipeline and registered test-point output
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            s_q   <= '0;
            sp_q  <= '0;
            out_q <= '0;
        end else begin
            s_q   <= s_d;
            sp_q  <= sp_d;
            out_q <= out_d;
        end
    end

    // Group switch FSM: a write always blanks, repeated writes restart it
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= ST_RUN;
            grp_q   <= 2'd0;
            blk_q   <= 4'd0;
        end else if (SEL_WR) begin
            state_q <= ST_BLANK;
            grp_q   <= SEL_DATA;
            blk_q   <= 4'(BLANK - 1);
        end else if (state_q == ST_BLANK) begin
            if (blk_q == 4'd0) begin
                state_q <= ST_RUN;
            end else begin
                blk_q <= blk_q - 4'd1;
            end
        end
    end

    // Saturating event counter on bit 0; clear and blanking take priority
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            evt_q <= 16'd0;
        end else if (EVT_CLR || SEL_WR || state_q == ST_BLANK) begin
            evt_q <= 16'd0;
        end else if (rise0 && evt_q != 16'hFFFF) begin
            evt_q <= evt_q + 16'd1;
        end
    end

    assign TP_OUT  = out_q;
    assign TP_GRP  = grp_q;
    assign TP_BUSY = (state_q == ST_BLANK);
    assign EVT_CNT = evt_q;

endmodule

// File: tb/tb_tp_debug_sel.sv
// Bench for tp_debug_sel: directed steps plus random traffic
// against a time-based reference model of the conditioner.
module tb_tp_debug_sel;

    localparam int STRETCH = 8;
    localparam int BLANK   = 4;
`ifdef TP_STRETCH_EN
    localparam int PULSE_W = STRETCH;
`else
    localparam int PULSE_W = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST_B;
    logic [13:0] g0, g1, g2, g3;
    logic        SEL_WR;
    logic [1:0]  SEL_DATA;
    logic        EVT_CLR;
    logic [13:0] TP_OUT;
    logic [1:0]  TP_GRP;
    logic        TP_BUSY;
    logic [15:0] EVT_CNT;

    int checks = 0;
    int errors = 0;

    tp_debug_sel #(.STRETCH(STRETCH), .BLANK(BLANK)) dut (
        .CLK(CLK), .RST_B(RST_B),
        .GRP0(g0), .GRP1(g1), .GRP2(g2), .GRP3(g3),
        .SEL_WR(SEL_WR), .SEL_DATA(SEL_DATA), .EVT_CLR(EVT_CLR),
        .TP_OUT(TP_OUT), .TP_GRP(TP_GRP), .TP_BUSY(TP_BUSY),
        .EVT_CNT(EVT_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: stretching expressed as time since last rising edge
    int          cyc = 0;
    logic [1:0]  m_grp;
    bit          m_blank;
    int          blank_until;
    logic [13:0] m_s, m_sp, m_out;
    logic [15:0] m_evt;
    int          last_rise [14];

    function automatic logic [13:0] pick(input logic [1:0] k);
        case (k)
            2'd0: return g0;
            2'd1: return g1;
            2'd2: return g2;
            default: return g3;
        endcase
    endfunction

    task automatic model_reset();
        m_grp = 0; m_blank = 0; blank_until = 0;
        m_s = 0; m_sp = 0; m_out = 0; m_evt = 0;
        for (int i = 0; i < 14; i++) last_rise[i] = -1000;
    endtask

    task automatic model_edge();
        logic [13:0] mux, rise, nout;
        bit          running;
        mux = pick(m_grp);
        running = !m_blank && !SEL_WR;
        rise = running ? (m_s & ~m_sp) : 14'd0;
        nout = 0;
        for (int i = 0; i < 14; i++) begin
            if (!running) last_rise[i] = -1000;
            else if (rise[i]) last_rise[i] = cyc;
`ifdef TP_STRETCH_EN
            nout[i] = running && (m_s[i] || (cyc - last_rise[i] < STRETCH));
`else
            nout[i] = running && m_s[i];
`endif
        end
        if (EVT_CLR || m_blank || SEL_WR) m_evt = 0;
        else if (rise[0] && m_evt != 16'hFFFF) m_evt = m_evt + 1;
        m_sp  = m_blank ? mux : m_s;
        m_s   = mux;
        m_out = nout;
        if (SEL_WR) begin
            m_grp = SEL_DATA; m_blank = 1; blank_until = cyc + BLANK;
        end else if (m_blank && cyc >= blank_until) begin
            m_blank = 0;
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("tp_out",  16'(TP_OUT),  16'(m_out));
        chk("tp_grp",  16'(TP_GRP),  16'(m_grp));
        chk("tp_busy", 16'(TP_BUSY), 16'(m_blank));
        chk("evt_cnt", EVT_CNT,      m_evt);
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later
    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
        @(negedge CLK);
    endtask

    initial begin
        int hi;
        int busy_n;
        RST_B = 0; SEL_WR = 0; SEL_DATA = 0; EVT_CLR = 0;
        g0 = 14'h3FFF; g1 = 14'h3FFF; g2 = 14'h3FFF; g3 = 14'h3FFF;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_tp_out", 16'(TP_OUT), 16'h0);
        chk("rst_tp_grp", 16'(TP_GRP), 16'h0);
        chk("rst_busy", 16'(TP_BUSY), 16'h0);
        chk("rst_evt", EVT_CNT, 16'h0);

        RST_B = 1;
        tick();
        chk("rel_edge1", 16'(TP_OUT), 16'h0);
        tick();
        chk("rel_edge2", 16'(TP_OUT), 16'h3FFF);

        g0 = 0; g1 = 0; g2 = 0; g3 = 0;
        repeat (12) tick();

        // Single-cycle pulse on bit 5
        g0 = 14'h0020;
        tick();
        g0 = 0;
        hi = 0;
        repeat (14) begin
            tick();
            hi += int'(TP_OUT[5]);
        end
        chk("pulse5_width", 16'(hi), 16'(PULSE_W));
        chk("pulse5_evt", EVT_CNT, 16'd1);

        // Pulses on bit 0 three cycles apart
        for (int p = 0; p < 4; p++) begin
            g0 = 14'h0001;
            tick();
            g0 = 0;
            tick();
            tick();
        end
        repeat (10) tick();
        chk("pulse0_evt", EVT_CNT, 16'd5);

        // Switch to group 2 held at 0x0001
        g2 = 14'h0001;
        SEL_WR = 1; SEL_DATA = 2;
        tick();
        SEL_WR = 0;
        chk("sel_grp", 16'(TP_GRP), 16'd2);
        busy_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            busy_n += int'(TP_BUSY);
        end
        chk("blank_len", 16'(busy_n), 16'(BLANK));
        chk("after_blank_out", 16'(TP_OUT), 16'h0001);
        chk("after_blank_evt", EVT_CNT, 16'h0);

        // Saturation near the top of the counter
        g2 = 0;
        repeat (3) tick();
        dut.evt_q = 16'hFFFD;
        m_evt = 16'hFFFD;
        for (int p = 0; p < 5; p++) begin
            g2 = 14'h0001;
            tick();
            g2 = 0;
            tick();
        end
        repeat (3) tick();
        chk("evt_sat", EVT_CNT, 16'hFFFF);

        // Clear coinciding with an edge on bit 0
        g2 = 14'h0001;
        tick();
        EVT_CLR = 1;
        tick();
        EVT_CLR = 0;
        chk("clr_wins", EVT_CNT, 16'h0);
        g2 = 0;
        repeat (3) tick();

        // Randomized traffic across all groups with occasional switches
        for (int n = 0; n < 400; n++) begin
            g0 = 14'($urandom & $urandom & $urandom);
            g1 = 14'($urandom & $urandom);
            g2 = 14'($urandom & $urandom & $urandom);
            g3 = 14'($urandom);
            SEL_WR   = ($urandom_range(0, 19) == 0);
            SEL_DATA = 2'($urandom);
            EVT_CLR  = ($urandom_range(0, 39) == 0);
            tick();
        end
        SEL_WR = 0; EVT_CLR = 0;

        // Asynchronous reset in the middle of a stretch
        g0 = 0; g1 = 0; g2 = 0; g3 = 0;
        SEL_WR = 1; SEL_DATA = 0;
        tick();
        SEL_WR = 0;
        repeat (8) tick();
        g0 = 14'h0004;
        tick();
        g0 = 0;
        repeat (2) tick();
        #2;
        RST_B = 0;
        #1;
        model_reset();
        chk("async_rst_out", 16'(TP_OUT), 16'h0);
        chk("async_rst_evt", EVT_CNT, 16'h0);
        @(negedge CLK);
        RST_B = 1;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
